// File: rtl/seq_hex_tx_fmt_if.sv
// ----------------------------------------------------------------------------
// seq_hex_tx_fmt_if
//   Bundles the signals between the sequencer result port, the hex formatter
//   and the UART transmitter byte handshake.
//
//   i_data      sequencer result word (DP_WIDTH bits)
//   i_valid     one-cycle strobe, i_data valid
//   o_ready     formatter can take a word this cycle (pending slot free)
//   i_tx_busy   UART transmitter busy
//   o_tx_data   ASCII character to the UART
//   o_tx_stb    one-cycle strobe, o_tx_data valid
//   o_drop_cnt  saturating count of dropped words
//   o_idle      formatter idle with nothing pending
//
//   slave  : formatter side
//   master : sequencer/UART side (producer of words, consumer of bytes)
// ----------------------------------------------------------------------------
interface seq_hex_tx_fmt_if #(
    parameter int DP_WIDTH = 8
);
    logic [DP_WIDTH-1:0] i_data;
    logic                i_valid;
    logic                o_ready;
    logic                i_tx_busy;
    logic [7:0]          o_tx_data;
    logic                o_tx_stb;
    logic [7:0]          o_drop_cnt;
    logic                o_idle;

    modport slave (
        input  i_data,
        input  i_valid,
        input  i_tx_busy,
        output o_ready,
        output o_tx_data,
        output o_tx_stb,
        output o_drop_cnt,
        output o_idle
    );

    modport master (
        output i_data,
        output i_valid,
        output i_tx_busy,
        input  o_ready,
        input  o_tx_data,
        input  o_tx_stb,
        input  o_drop_cnt,
        input  o_idle
    );
endinterface

// File: rtl/seq_hex_tx_fmt.sv
// ----------------------------------------------------------------------------
// seq_hex_tx_fmt
//   Formatter between the sequencer result output and the UART transmitter.
//   Each data word becomes DP_WIDTH/4 uppercase ASCII hex characters, most
//   significant nibble first, optionally followed by CR LF. Characters are
//   handed to the UART one at a time over a strobe/busy handshake. One word
//   can wait in a pending register while another is being sent; words that
//   arrive when both are occupied are dropped and counted.
//
// Parameters
//   DP_WIDTH  data word width, multiple of 4
//   EOL_EN    1: append 0x0D 0x0A after each word
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   bus       seq_hex_tx_fmt_if slave modport (word input, UART handshake,
//             drop counter, idle flag)
// ----------------------------------------------------------------------------
module seq_hex_tx_fmt #(
    parameter int DP_WIDTH = 8,
    parameter bit EOL_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    seq_hex_tx_fmt_if.slave  bus
);

    localparam int unsigned NHEX  = DP_WIDTH / 4;
    localparam int unsigned NCHAR = NHEX + (EOL_EN ? 2 : 0);
    localparam int unsigned CW    = $clog2(NCHAR + 1);

    localparam logic [CW-1:0] NHEX_C = CW'(NHEX);
    localparam logic [CW-1:0] LAST_C = CW'(NCHAR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STB,
        S_WAIT_HI,
        S_WAIT_LO,
        S_NEXT
    } state_t;

    state_t              state;
    logic [DP_WIDTH-1:0] shreg;
    logic [DP_WIDTH-1:0] pend_data;
    logic                pend_vld;
    logic [CW-1:0]       char_idx;
    logic [7:0]          tx_data;
    logic                tx_stb;
    logic [7:0]          drop_cnt;

    logic [7:0]          cur_char;
    logic                last_char;
    logic                pend_take;
    logic                load_direct;
    logic                to_pend;
    logic                drop;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h41 + {4'h0, nib - 4'd10};
    endfunction

    // The active word is shifted left one nibble per character, so the
    // character to send is always taken from the top nibble; once the hex
    // digits are used up the index selects CR then LF.
    always_comb begin
        cur_char = 8'h0A;
        if (char_idx < NHEX_C) begin
            cur_char = hex_ascii(shreg[DP_WIDTH-1 -: 4]);
        end else if (char_idx == NHEX_C) begin
            cur_char = 8'h0D;
        end
    end

    assign last_char = (char_idx == LAST_C);

    // The pending word leaves its slot when the FSM picks it up: either in
    // IDLE, or in NEXT when the active word has just finished. A word that
    // arrives in that same cycle reuses the freed slot instead of dropping.
    always_comb begin
        pend_take   = pend_vld && ((state == S_IDLE) || ((state == S_NEXT) && last_char));
        load_direct = bus.i_valid && (state == S_IDLE) && !pend_vld;
        to_pend     = bus.i_valid && !load_direct && (!pend_vld || pend_take);
        drop        = bus.i_valid && !load_direct && pend_vld && !pend_take;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            pend_data <= '0;
            pend_vld  <= 1'b0;
            char_idx  <= '0;
            tx_data   <= '0;
            tx_stb    <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            tx_stb <= 1'b0;

            if (to_pend) begin
                pend_data <= bus.i_data;
                pend_vld  <= 1'b1;
            end else if (pend_take) begin
                pend_vld  <= 1'b0;
            end

            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            unique case (state)
                S_IDLE: begin
                    if (pend_vld) begin
                        shreg    <= pend_data;
                        char_idx <= '0;
                        state    <= S_STB;
                    end else if (bus.i_valid) begin
                        shreg    <= bus.i_data;
                        char_idx <= '0;
                        state    <= S_STB;
                    end
                end
                S_STB: begin
                    if (!bus.i_tx_busy) begin
                        tx_stb  <= 1'b1;
                        tx_data <= cur_char;
                        state   <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (bus.i_tx_busy) begin
                        state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!bus.i_tx_busy) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (!last_char) begin
                        char_idx <= char_idx + CW'(1);
                        shreg    <= shreg << 4;
                        state    <= S_STB;
                    end else if (pend_vld) begin
                        shreg    <= pend_data;
                        char_idx <= '0;
                        state    <= S_STB;
                    end else begin
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_tx_data  = tx_data;
    assign bus.o_tx_stb   = tx_stb;
    assign bus.o_drop_cnt = drop_cnt;
    assign bus.o_ready    = ~pend_vld;
    assign bus.o_idle     = (state == S_IDLE) && !pend_vld;

endmodule

// File: tb/tb_seq_hex_tx_fmt.sv
// ----------------------------------------------------------------------------
// tb_seq_hex_tx_fmt
//   Two formatter instances: index 0 is DP_WIDTH=8 with CR LF, index 1 is
//   DP_WIDTH=16 without. Each has its own UART model that stays busy for a
//   number of cycles after every strobe. A word-slot model (active/pending)
//   predicts acceptance, drops and the byte stream; directed cases pin the
//   model with literal byte sequences.
// ----------------------------------------------------------------------------
module tb_seq_hex_tx_fmt;

    localparam int QN  = 4096;
    localparam int NCH = 4;     // characters per word for both instances

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic        vld        [2];
    logic [15:0] dat        [2];
    logic        force_busy [2];
    logic        busy       [2];
    int          ucnt       [2];
    bit          rand_busy = 1'b0;

    logic       stb_o [2];
    logic       rdy_o [2];
    logic       idl_o [2];
    logic [7:0] txd_o [2];
    logic [7:0] drp_o [2];

    seq_hex_tx_fmt_if #(.DP_WIDTH(8))  b8  ();
    seq_hex_tx_fmt_if #(.DP_WIDTH(16)) b16 ();

    seq_hex_tx_fmt #(.DP_WIDTH(8), .EOL_EN(1'b1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    seq_hex_tx_fmt #(.DP_WIDTH(16), .EOL_EN(1'b0)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    assign b8.i_valid   = vld[0];
    assign b8.i_data    = dat[0][7:0];
    assign b8.i_tx_busy = busy[0];
    assign b16.i_valid   = vld[1];
    assign b16.i_data    = dat[1];
    assign b16.i_tx_busy = busy[1];

    assign busy[0] = force_busy[0] | (ucnt[0] != 0);
    assign busy[1] = force_busy[1] | (ucnt[1] != 0);

    assign stb_o[0] = b8.o_tx_stb;
    assign rdy_o[0] = b8.o_ready;
    assign idl_o[0] = b8.o_idle;
    assign txd_o[0] = b8.o_tx_data;
    assign drp_o[0] = b8.o_drop_cnt;
    assign stb_o[1] = b16.o_tx_stb;
    assign rdy_o[1] = b16.o_ready;
    assign idl_o[1] = b16.o_idle;
    assign txd_o[1] = b16.o_tx_data;
    assign drp_o[1] = b16.o_drop_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy for a while starting the cycle after each strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (stb_o[k] === 1'b1)
                ucnt[k] <= rand_busy ? int'($urandom_range(1, 12)) : 10;
            else if (ucnt[k] != 0)
                ucnt[k] <= ucnt[k] - 1;
        end
    end

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: actual=%0h required=%0h at t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit       has_act   [2];
    bit       has_pend  [2];
    bit       rel_now   [2];
    bit       need_busy [2];
    int       ph        [2];
    int       nbytes    [2];
    int       drop_exp  [2];
    int       wp        [2];
    int       rp        [2];
    int       cap_n     [2];
    bit [7:0] last_tx   [2];
    bit [7:0] eq        [2][QN];
    bit [7:0] cap       [2][QN];
    int       cap_cyc   [2][QN];

    task automatic push_word(input int k, input logic [15:0] w);
        int nd;
        int d;
        nd = (k == 0) ? 2 : 4;
        for (int i = 0; i < nd; i++) begin
            d = int'((w >> (4 * (nd - 1 - i))) & 16'h000F);
            eq[k][wp[k] % QN] = (d < 10) ? 8'(48 + d) : 8'(55 + d);
            wp[k]++;
        end
        if (k == 0) begin
            eq[k][wp[k] % QN] = 8'h0D; wp[k]++;
            eq[k][wp[k] % QN] = 8'h0A; wp[k]++;
        end
    endtask

    always @(negedge clk) begin : cmp
        bit rel;
        bit idle_st;
        bit moved;
        for (int k = 0; k < 2; k++) begin
            chk(k, "o_ready", 32'(rdy_o[k]), 32'(!has_pend[k]));
            chk(k, "o_idle", 32'(idl_o[k]), 32'(!has_act[k] && !has_pend[k]));
            chk(k, "o_drop_cnt", 32'(drp_o[k]), 32'(drop_exp[k]));
            if (stb_o[k] === 1'b1) begin
                chk(k, "stb_while_busy", 32'(busy[k]), 32'd0);
                chk(k, "two_stb_one_busy", 32'(need_busy[k]), 32'd0);
                chk(k, "stb_expected", 32'(wp[k] != rp[k]), 32'd1);
                if (wp[k] != rp[k]) begin
                    last_tx[k] = eq[k][rp[k] % QN];
                    rp[k]++;
                end
                cap[k][cap_n[k] % QN]     = txd_o[k];
                cap_cyc[k][cap_n[k] % QN] = cyc;
                cap_n[k]++;
                nbytes[k]++;
                need_busy[k] = 1'b1;
                if (nbytes[k] == NCH) ph[k] = 1;
            end
            chk(k, "o_tx_data", 32'(txd_o[k]), 32'(last_tx[k]));

            if (rst) begin
                has_act[k] = 0; has_pend[k] = 0; rel_now[k] = 0; need_busy[k] = 0;
                ph[k] = 0; nbytes[k] = 0; drop_exp[k] = 0; last_tx[k] = '0; rp[k] = wp[k];
            end else begin
                if (busy[k]) need_busy[k] = 1'b0;
                rel = rel_now[k];
                rel_now[k] = 1'b0;
                // A word's slot frees the cycle after the UART finishes its last byte.
                if (ph[k] == 1) begin
                    if (busy[k]) ph[k] = 2;
                end else if (ph[k] == 2 && !busy[k]) begin
                    ph[k] = 0;
                    rel_now[k] = 1'b1;
                end
                idle_st = !has_act[k];
                moved = 1'b0;
                if (rel) begin
                    nbytes[k] = 0;
                    if (has_pend[k]) has_pend[k] = 0;
                    else has_act[k] = 0;
                end else if (idle_st && has_pend[k]) begin
                    has_act[k] = 1; has_pend[k] = 0; moved = 1'b1;
                end
                if (vld[k]) begin
                    if (idle_st && !moved) begin
                        has_act[k] = 1;
                        push_word(k, (k == 0) ? {8'h00, dat[0][7:0]} : dat[1]);
                    end else if (!has_pend[k]) begin
                        has_pend[k] = 1;
                        push_word(k, (k == 0) ? {8'h00, dat[0][7:0]} : dat[1]);
                    end else if (drop_exp[k] < 255) begin
                        drop_exp[k]++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        step(); step();
        while (!(idl_o[k] === 1'b1 && !busy[k]) && n < 4000) begin
            step();
            n++;
        end
        chk(k, "drain_timeout", 32'(n >= 4000), 32'd0);
    endtask

    task automatic chk_log(input int k, input int base, input int n, input logic [63:0] exp, input string nm);
        chk(k, {nm, "_count"}, 32'(cap_n[k] - base), 32'(n));
        for (int i = 0; i < n; i++)
            chk(k, $sformatf("%s_byte%0d", nm, i), 32'(cap[k][(base + i) % QN]), 32'(exp[8*(n-1-i) +: 8]));
    endtask

    initial begin
        int base;
        int base2;
        int tv;
        int n;
        int p;
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; dat[k] = '0; force_busy[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk(0, "reset_ready", 32'(rdy_o[0]), 32'd1);
        chk(0, "reset_idle", 32'(idl_o[0]), 32'd1);
        chk(0, "reset_stb", 32'(stb_o[0]), 32'd0);
        chk(0, "reset_data", 32'(txd_o[0]), 32'd0);
        chk(1, "reset_drop", 32'(drp_o[1]), 32'd0);

        // T1: single word, latency and byte sequence
        base = cap_n[0];
        dat[0] = 16'h00A5; vld[0] = 1'b1; tv = cyc;
        step(); vld[0] = 1'b0;
        wait_idle(0);
        chk_log(0, base, 4, 64'h41350D0A, "t1");
        chk(0, "t1_latency", 32'(cap_cyc[0][base % QN] - tv), 32'd2);
        chk(0, "t1_idle", 32'(idl_o[0]), 32'd1);

        // T2: two words back to back
        base = cap_n[0];
        dat[0] = 16'h0009; vld[0] = 1'b1; step();
        dat[0] = 16'h00F0; step();
        vld[0] = 1'b0;
        wait_idle(0);
        chk_log(0, base, 8, 64'h30390D0A46300D0A, "t2");
        chk(0, "t2_drop", 32'(drp_o[0]), 32'd0);

        // T3: three words, third dropped
        base = cap_n[0];
        vld[0] = 1'b1;
        dat[0] = 16'h0012; step();
        dat[0] = 16'h0034; step();
        dat[0] = 16'h0056;
        chk(0, "t3_ready_pending", 32'(rdy_o[0]), 32'd0);
        step(); vld[0] = 1'b0;
        chk(0, "t3_drop", 32'(drp_o[0]), 32'd1);
        wait_idle(0);
        chk_log(0, base, 8, 64'h31320D0A33340D0A, "t3");

        // T4: 300 strobes while the UART reports busy
        base = cap_n[0];
        force_busy[0] = 1'b1;
        vld[0] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            dat[0] = 16'(i);
            step();
        end
        vld[0] = 1'b0;
        step();
        chk(0, "t4_drop_sat", 32'(drp_o[0]), 32'd255);
        chk(0, "t4_ready", 32'(rdy_o[0]), 32'd0);
        force_busy[0] = 1'b0;
        wait_idle(0);
        chk_log(0, base, 8, 64'h30300D0A30310D0A, "t4");
        chk(0, "t4_drop_hold", 32'(drp_o[0]), 32'd255);

        // T5: 16-bit word, no line ending
        base = cap_n[1];
        dat[1] = 16'hBEEF; vld[1] = 1'b1;
        step(); vld[1] = 1'b0;
        wait_idle(1);
        chk_log(1, base, 4, 64'h42454546, "t5");

        // T6: reset after the second character
        base = cap_n[0];
        dat[0] = 16'h003C; vld[0] = 1'b1;
        step(); vld[0] = 1'b0;
        n = 0;
        while (cap_n[0] - base < 2 && n < 500) begin
            step();
            n++;
        end
        chk(0, "t6_timeout", 32'(n >= 500), 32'd0);
        chk_log(0, base, 2, 64'h3343, "t6");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk(0, "t6_stb", 32'(stb_o[0]), 32'd0);
        chk(0, "t6_idle", 32'(idl_o[0]), 32'd1);
        chk(0, "t6_drop", 32'(drp_o[0]), 32'd0);
        base2 = cap_n[0];
        repeat (60) step();
        chk(0, "t6_no_more_stb", 32'(cap_n[0] - base2), 32'd0);

        // Randomized traffic on both instances, varying arrival rate
        rand_busy = 1'b1;
        for (int seg = 0; seg < 3; seg++) begin
            p = (seg == 0) ? 3 : ((seg == 1) ? 8 : 30);
            for (int i = 0; i < 600; i++) begin
                for (int k = 0; k < 2; k++) begin
                    vld[k] = ($urandom_range(0, 99) < p);
                    dat[k] = 16'($urandom);
                end
                step();
            end
        end
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        wait_idle(0);
        wait_idle(1);
        chk(0, "leftover_bytes", 32'(wp[0] - rp[0]), 32'd0);
        chk(1, "leftover_bytes", 32'(wp[1] - rp[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
